alu_rr_sched: RTL and testbench
===============================

Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one tinyalu between NUM_REQ requesters.
- Arbitrates among pending requests and latches the winner's opcode and operands.
- Drives the ALU start/opcode/A/B with the correct per-opcode latency, captures the result, and returns it tagged with the requester ID.
- Sits between the requester agents and the ALU interface signals.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand width; result width is 2*DATA_W.
- SHORT_LAT, 1, start-high cycles for NOP/ADD/SUB/NOT/XOR/AND.
- LONG_LAT, 3, start-high cycles for MUL/INC (two-stage internal ALU pipe plus result register).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held until granted.
- req_opcode  in  3*NUM_REQ  packed opcodes, requester i at [3i+2:3i].
- req_a  in  DATA_W*NUM_REQ  packed operand A.
- req_b  in  DATA_W*NUM_REQ  packed operand B.
- req_grant  out  NUM_REQ  one-hot, one-cycle pulse; operands latched on this cycle.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  $clog2(NUM_REQ)  requester owning rsp_result.
- rsp_result  out  2*DATA_W  captured result.
- busy  out  1  high from grant through the response cycle.
- alu_start  out  1  ALU start.
- alu_opcode  out  3  ALU opcode.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_result  in  2*DATA_W  ALU result.
- alu_done  in  1  ALU done (equals ~alu_start).
- err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Opcode encoding: NOP=0, ADD=1, SUB=2, NOT=3, XOR=4, AND=5, MUL=6, INC=7. LAT = LONG_LAT for MUL/INC, else SHORT_LAT.
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; cycle counter 0.
- IDLE:
  - If any req_valid, the winner is the first set bit searching from rr_ptr upward with wrap.
  - Pulse req_grant[winner]; latch opcode/A/B into the ALU output registers.
  - Set rr_ptr=(winner+1) mod NUM_REQ; go to EXEC. busy goes high.
  - No request: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - alu_start=1 for exactly LAT consecutive cycles; opcode/A/B held stable.
  - Counter counts 1..LAT, then go to RESP.
- RESP:
  - alu_start=0 for one cycle.
  - At the end of this cycle, rsp_result<=alu_result (forced to 0 when opcode is NOP), rsp_id<=winner, rsp_valid<=1. Go to IDLE.
- rsp_valid is high during the first IDLE cycle after RESP. A new grant may issue in that same cycle.
- busy is high in EXEC and RESP.
- Timing with grant in cycle T: EXEC occupies T+1..T+LAT, RESP is T+LAT+1, rsp_valid is at T+LAT+2.
  - Back-to-back short ops: one op per 3 cycles.
  - Back-to-back long ops: one op per 5 cycles.
- req_valid still high after a grant is a new request, arbitrated normally.
- Requests arriving during EXEC/RESP wait; no loss, no reordering per requester.
- Simultaneous requests from all requesters: served ptr, ptr+1, ... with wrap. No requester waits more than NUM_REQ-1 ops.
- Invalid NUM_REQ (<2 or >8): behaviour undefined; a simulation $error fires at elaboration.
- Reset asserted mid-operation:
  - All outputs clear immediately, including alu_start.
  - The in-flight op is dropped with no rsp_valid; rr_ptr returns to 0.
- Arithmetic is done entirely by the ALU; the scheduler only zero-forces the NOP result.

Optional Feature:
- Macro: ALU_DONE_CHECK_EN.
- Defined: every cycle outside reset, if alu_done != ~alu_start, err sets and remains set until reset. In RESP, an alu_result containing X/Z also sets err (simulation-only check, synthesis-ignored).
- Undefined: err tied to 0; no check logic present.

Test Plan:
- Reset, then req_valid=4'b0001, ADD A=8'h12 B=8'h34 -> grant[0] pulse; alu_start high 1 cycle; rsp_valid 3 cycles after grant with rsp_id=0, rsp_result=16'h0046.
- Req1 MUL A=8'hFF B=8'hFF -> alu_start high 3 consecutive cycles; rsp_result=16'hFE01 at grant+5; busy high 4 cycles.
- All 4 requesters asserted simultaneously with distinct SUB ops, rr_ptr=0 -> grants in order 0,1,2,3; responses tagged 0,1,2,3; a grant coincides with each previous rsp_valid.
- Req2 holds req_valid continuously while req3 requests once -> after req2's grant, req3 is granted before req2's second op.
- Assert reset during the 2nd EXEC cycle of an INC -> alu_start=0 and busy=0 immediately; no rsp_valid; the next grant after reset searches from requester 0.
- With ALU_DONE_CHECK_EN defined, force alu_done=1 while alu_start=1 -> err=1, stays 1 until reset. Without the macro, err stays 0.

Source files
------------

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler sharing one tinyalu among NUM_REQ requesters.
// Each granted request runs on the ALU for its opcode latency. The result is then
// returned to the requester, tagged with the requester's ID.
// Optional build macro: ALU_DONE_CHECK_EN enables the sticky alu_done protocol check on err.
// When that macro is not defined, err is tied low.
module alu_rr_sched #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SHORT_LAT = 1,
    parameter int unsigned LONG_LAT  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [3*NUM_REQ-1:0]       req_opcode,
    input  logic [DATA_W*NUM_REQ-1:0]  req_a,
    input  logic [DATA_W*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [2*DATA_W-1:0]        rsp_result,
    output logic                       busy,
    output logic                       alu_start,
    output logic [2:0]                 alu_opcode,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    input  logic [2*DATA_W-1:0]        alu_result,
    input  logic                       alu_done,
    output logic                       err
);

    localparam int unsigned ID_W    = $clog2(NUM_REQ);
    localparam int unsigned OP_W    = 3;
    localparam int unsigned RES_W   = 2 * DATA_W;
    localparam int unsigned MAX_LAT = (LONG_LAT > SHORT_LAT) ? LONG_LAT : SHORT_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [OP_W-1:0] OP_NOP = 3'd0;
    localparam logic [OP_W-1:0] OP_MUL = 3'd6;
    localparam logic [OP_W-1:0] OP_INC = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Elaboration-time guard on the supported requester count.
    if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
        $error("alu_rr_sched: NUM_REQ=%0d is outside the supported range 2..8", NUM_REQ);
    end

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   winner_q, winner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start_q, start_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [RES_W-1:0]  rsp_result_q, rsp_result_d;

    logic              found_c;
    logic [ID_W-1:0]   winner_c;
    logic [ID_W-1:0]   next_ptr_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [CNT_W-1:0]  lat_c;

    logic [OP_W-1:0]   req_op_arr [NUM_REQ];
    logic [DATA_W-1:0] req_a_arr  [NUM_REQ];
    logic [DATA_W-1:0] req_b_arr  [NUM_REQ];

    // Split the packed per-requester buses into indexable arrays.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_op_arr[gi] = req_opcode[OP_W*gi +: OP_W];
        assign req_a_arr[gi]  = req_a[DATA_W*gi +: DATA_W];
        assign req_b_arr[gi]  = req_b[DATA_W*gi +: DATA_W];
    end

    // Requester index `off` positions after `base`, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    // Round-robin search: first pending requester at or after rr_ptr, with wrap.
    always_comb begin
        found_c  = 1'b0;
        winner_c = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found_c && req_valid[wrap_idx(rr_ptr_q, k)]) begin
                found_c  = 1'b1;
                winner_c = wrap_idx(rr_ptr_q, k);
            end
        end
        next_ptr_c = (winner_c == ID_W'(NUM_REQ - 1)) ? '0 : (winner_c + ID_W'(1));
    end

    // The grant pulse is decided and shown in the same IDLE cycle; it is therefore combinational.
    always_comb begin
        grant_c = '0;
        if ((state_q == IDLE) && found_c && !reset) begin
            grant_c = NUM_REQ'(1) << winner_c;
        end
    end

    // Number of start-high cycles for the operation currently latched.
    always_comb begin
        lat_c = CNT_W'(SHORT_LAT);
        if ((op_q == OP_MUL) || (op_q == OP_INC)) begin
            lat_c = CNT_W'(LONG_LAT);
        end
    end

    // Next-state and next-output logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        winner_d     = winner_q;
        cnt_d        = cnt_q;
        start_d      = 1'b0;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        busy_d       = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;

        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d  = EXEC;
                    rr_ptr_d = next_ptr_c;
                    winner_d = winner_c;
                    cnt_d    = CNT_W'(1);
                    start_d  = 1'b1;
                    op_d     = req_op_arr[winner_c];
                    a_d      = req_a_arr[winner_c];
                    b_d      = req_b_arr[winner_c];
                    busy_d   = 1'b1;
                end
            end
            EXEC: begin
                busy_d = 1'b1;
                if (cnt_q == lat_c) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    start_d = 1'b1;
                end
            end
            RESP: begin
                state_d      = IDLE;
                cnt_d        = '0;
                rsp_valid_d  = 1'b1;
                rsp_id_d     = winner_q;
                rsp_result_d = (op_q == OP_NOP) ? '0 : alu_result;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            winner_q     <= '0;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            winner_q     <= winner_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign req_grant  = grant_c;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;
    assign alu_start  = start_q;
    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;

`ifdef ALU_DONE_CHECK_EN
    logic err_q;

    // Sticky error: alu_done must always equal ~alu_start; an unknown result seen in RESP also flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            if (alu_done != ~start_q) begin
                err_q <= 1'b1;
            end
`ifndef SYNTHESIS
            if ((state_q == RESP) && $isunknown(alu_result)) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

    assign err = err_q;
`else
    logic unused_alu_done;
    assign unused_alu_done = alu_done;
    assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Testbench for alu_rr_sched: a transaction-level model predicts the grants, busy windows,
// start lengths and responses. A monitor compares the DUT against those predictions at each negedge.
`timescale 1ns/1ps
module tb_alu_rr_sched;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int RW = 16;
    localparam int SL = 1;
    localparam int LL = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [3*N-1:0]    req_opcode;
    logic [DW*N-1:0]   req_a;
    logic [DW*N-1:0]   req_b;
    logic [N-1:0]      req_grant;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [RW-1:0]     rsp_result;
    logic              busy;
    logic              alu_start;
    logic [2:0]        alu_opcode;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [RW-1:0]     alu_result;
    logic              alu_done;
    logic              err;
    logic              done_corrupt;

    alu_rr_sched #(.NUM_REQ(N), .DATA_W(DW), .SHORT_LAT(SL), .LONG_LAT(LL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .busy(busy), .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_done(alu_done), .err(err)
    );

    always #5 clk = ~clk;

    // tinyalu stand-in: the result is only meaningful once start drops, and NOP yields garbage.
    function automatic logic [RW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            3'd0:    return 16'hDEAD;
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return 16'(a) - 16'(b);
            3'd3:    return {8'h00, ~a};
            3'd4:    return {8'h00, a ^ b};
            3'd5:    return {8'h00, a & b};
            3'd6:    return 16'(a) * 16'(b);
            default: return 16'(a) + 16'd1;
        endcase
    endfunction

    assign alu_done = (~alu_start) ^ done_corrupt;
    always_comb alu_result = alu_start ? 16'hBAD0 : ref_alu(alu_opcode, alu_a, alu_b);

    typedef struct {
        int            id;
        logic [RW-1:0] res;
        int            cyc;
    } rsp_t;

    rsp_t          rsp_q[$];
    int            lat_q[$];
    int            id_log[$];
    logic [RW-1:0] last_res;

    logic [N-1:0]  pend, hold;
    logic [2:0]    p_op [N];
    logic [DW-1:0] p_a  [N];
    logic [DW-1:0] p_b  [N];
    int            ptr, free_at, busy_from, busy_to, cyc;
    logic [N-1:0]  exp_grant_now;
    logic          exp_busy_now;
    logic          mon_en;
    int            n_checks, n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int lat_of(input logic [2:0] op);
        return ((op == 3'd6) || (op == 3'd7)) ? LL : SL;
    endfunction

    // First pending requester searching upward from p with wrap.
    function automatic int pick(input logic [N-1:0] req, input int p);
        for (int k = 0; k < N; k++) begin
            if (req[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [2:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        pend[i] = 1'b1;
        p_op[i] = op;
        p_a[i]  = a;
        p_b[i]  = b;
    endtask

    // One clock cycle: drive requests and predict this cycle's grant and busy.
    task automatic step();
        int   w;
        int   lat;
        rsp_t e;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            req_opcode[3*i +: 3] = p_op[i];
            req_a[DW*i +: DW]    = p_a[i];
            req_b[DW*i +: DW]    = p_b[i];
        end
        req_valid     = pend;
        exp_grant_now = '0;
        if ((cyc >= free_at) && (pend != '0)) begin
            w   = pick(pend, ptr);
            lat = lat_of(p_op[w]);
            exp_grant_now[w] = 1'b1;
            e.id  = w;
            e.res = (p_op[w] == 3'd0) ? 16'h0000 : ref_alu(p_op[w], p_a[w], p_b[w]);
            e.cyc = cyc + lat + 2;
            rsp_q.push_back(e);
            lat_q.push_back(lat);
            busy_from = cyc + 1;
            busy_to   = cyc + lat + 1;
            free_at   = cyc + lat + 2;
            ptr       = (w + 1) % N;
            if (!hold[w]) pend[w] = 1'b0;
        end
        exp_busy_now = (cyc >= busy_from) && (cyc <= busy_to);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (((pend != '0) || (rsp_q.size() != 0)) && (n < limit)) begin
            step();
            n++;
        end
        repeat (2) step();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        #1;
        chk("rst_alu_start", 32'(alu_start), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_result", 32'(rsp_result), 32'(0));
        chk("rst_grant", 32'(req_grant), 32'(0));
        rsp_q.delete();
        lat_q.delete();
        pend          = '0;
        hold          = '0;
        ptr           = 0;
        free_at       = 0;
        busy_from     = 1;
        busy_to       = 0;
        exp_grant_now = '0;
        exp_busy_now  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: compares grant, busy, start run length and responses against the predictions.
    initial begin : monitor
        int   run;
        rsp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                run = 0;
                continue;
            end
            chk("grant", 32'(req_grant), 32'(exp_grant_now));
            chk("busy", 32'(busy), 32'(exp_busy_now));
            if (alu_start) begin
                run++;
            end else if (run > 0) begin
                if (lat_q.size() == 0) chk("start_len", 32'(run), 32'(0));
                else chk("start_len", 32'(run), 32'(lat_q.pop_front()));
                run = 0;
            end
            if ((rsp_q.size() != 0) && (rsp_q[0].cyc == cyc)) begin
                e = rsp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1));
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_result", 32'(rsp_result), 32'(e.res));
            end else begin
                chk("rsp_valid_idle", 32'(rsp_valid), 32'(0));
            end
            if (rsp_valid) begin
                id_log.push_back(int'(rsp_id));
                last_res = rsp_result;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset        = 1'b0;
        req_valid    = '0;
        req_opcode   = '0;
        req_a        = '0;
        req_b        = '0;
        done_corrupt = 1'b0;
        mon_en       = 1'b0;
        n_checks     = 0;
        n_pass       = 0;
        cyc          = 0;
        pend         = '0;
        hold         = '0;
        for (int i = 0; i < N; i++) begin
            p_op[i] = '0;
            p_a[i]  = '0;
            p_b[i]  = '0;
        end
        #2;
        do_reset();
        chk("rst_err", 32'(err), 32'(0));
        mon_en = 1'b1;

        // Single ADD from requester 0.
        id_log.delete();
        set_req(0, 3'd1, 8'h12, 8'h34);
        drain(50);
        chk("add_result", 32'(last_res), 32'h0046);
        chk("add_id", 32'(id_log.size() > 0 ? id_log[0] : -1), 32'(0));

        // Single MUL from requester 1.
        set_req(1, 3'd6, 8'hFF, 8'hFF);
        drain(50);
        chk("mul_result", 32'(last_res), 32'hFE01);

        // All four requesters at once, pointer back at 0.
        do_reset();
        id_log.delete();
        for (int i = 0; i < N; i++) set_req(i, 3'd2, DW'(8'h40 + 8'(i * 9)), DW'(i + 3));
        drain(80);
        for (int i = 0; i < N; i++)
            chk("all4_order", 32'(id_log.size() > i ? id_log[i] : -1), 32'(i));

        // Requester 2 holds its request; requester 3 must get in before 2's second op.
        id_log.delete();
        hold[2] = 1'b1;
        set_req(2, 3'd4, 8'hA5, 8'h3C);
        step();
        set_req(3, 3'd5, 8'hF0, 8'h3C);
        repeat (7) step();
        hold[2] = 1'b0;
        drain(60);
        chk("fair_0", 32'(id_log.size() > 0 ? id_log[0] : -1), 32'(2));
        chk("fair_1", 32'(id_log.size() > 1 ? id_log[1] : -1), 32'(3));
        chk("fair_2", 32'(id_log.size() > 2 ? id_log[2] : -1), 32'(2));

        // Reset during the second EXEC cycle of an INC.
        do_reset();
        set_req(1, 3'd7, 8'h7F, 8'h00);
        step();
        step();
        step();
        chk("inc_start_pre_reset", 32'(alu_start), 32'(1));
        do_reset();
        id_log.delete();
        set_req(0, 3'd1, 8'h01, 8'h02);
        set_req(3, 3'd1, 8'h03, 8'h04);
        drain(60);
        chk("post_reset_first", 32'(id_log.size() > 0 ? id_log[0] : -1), 32'(0));

        // Random traffic.
        for (int s = 0; s < 400; s++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0))
                    set_req(i, 3'($urandom_range(0, 7)), DW'($urandom), DW'($urandom));
            end
            step();
        end
        drain(200);

`ifdef ALU_DONE_CHECK_EN
        do_reset();
        set_req(0, 3'd6, 8'h11, 8'h22);
        step();
        step();
        chk("err_before", 32'(err), 32'(0));
        done_corrupt = 1'b1;
        step();
        done_corrupt = 1'b0;
        step();
        chk("err_set", 32'(err), 32'(1));
        drain(50);
        chk("err_sticky", 32'(err), 32'(1));
        do_reset();
        chk("err_cleared", 32'(err), 32'(0));
`else
        chk("err_tied_low", 32'(err), 32'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
